// File: rtl/bubble_pq.sv
// Sorted-array priority queue: min key at the head, insert bubbles one compare-swap per cycle.
// Optional sticky overflow/underflow flags (ovf, udf) when BUBBLE_PQ_ERR_FLAGS_EN is defined.
module bubble_pq #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned KEY_W = 8,
   parameter int unsigned VAL_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   enq,
   input  logic                   deq,
   input  logic [KEY_W+VAL_W-1:0] kvi,
   output logic [KEY_W+VAL_W-1:0] kvo,
   output logic                   full,
   output logic                   empty,
   output logic                   busy
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
   ,
   output logic                   ovf,
   output logic                   udf
`endif
);

   localparam int unsigned W  = KEY_W + VAL_W;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   typedef enum logic {IDLE, BUBBLE} state_t;

   state_t          state;
   logic [W-1:0]    arr [DEPTH];
   logic [CW-1:0]   count;
   logic [PW-1:0]   p;
   logic [PW-1:0]   pm1;
   logic [PW-1:0]   tail_idx;
   logic [PW-1:0]   last_idx;
   logic            do_swap;

   assign pm1      = p - PW'(1);
   assign tail_idx = PW'(count);
   assign last_idx = PW'(count - CW'(1));
   // Strict compare: an equal key stops the bubble, keeping ties in FIFO order.
   assign do_swap  = (p != '0) && (arr[p][W-1 -: KEY_W] < arr[pm1][W-1 -: KEY_W]);

   assign kvo   = arr[0];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign busy  = (state == BUBBLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         count <= '0;
         p     <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) arr[i] <= '0;
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
         ovf   <= 1'b0;
         udf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (enq && deq && !empty) begin
                  // Replace: drop the head and place the new entry at the current tail.
                  for (int unsigned i = 0; i < DEPTH - 1; i++) arr[i] <= arr[i+1];
                  arr[DEPTH-1]   <= '0;
                  arr[last_idx]  <= kvi;
                  p              <= last_idx;
                  state          <= BUBBLE;
               end else if (enq && !full) begin
                  arr[tail_idx] <= kvi;
                  p             <= tail_idx;
                  count         <= count + CW'(1);
                  state         <= BUBBLE;
               end else if (deq && !enq && !empty) begin
                  for (int unsigned i = 0; i < DEPTH - 1; i++) arr[i] <= arr[i+1];
                  arr[DEPTH-1] <= '0;
                  count        <= count - CW'(1);
               end
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
               if (enq && !deq && full)  ovf <= 1'b1;
               if (deq && !enq && empty) udf <= 1'b1;
`endif
            end
            BUBBLE: begin
               if (do_swap) begin
                  arr[p]   <= arr[pm1];
                  arr[pm1] <= arr[p];
                  p        <= pm1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bubble_pq.sv
// Randomized and directed bench for bubble_pq against a sorted-queue reference model.
module tb_bubble_pq;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned KEY_W = 8;
   localparam int unsigned VAL_W = 8;
   localparam int unsigned W     = KEY_W + VAL_W;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         enq = 1'b0;
   logic         deq = 1'b0;
   logic [W-1:0] kvi = '0;
   logic [W-1:0] kvo;
   logic         full, empty, busy;
   logic         ovf, udf;

   int n_tests = 0;
   int n_fail  = 0;

   logic [W-1:0] q [$];
   logic         m_ovf = 1'b0;
   logic         m_udf = 1'b0;

   bubble_pq #(.DEPTH(DEPTH), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
      .clk   (clk),
      .rst   (rst),
      .enq   (enq),
      .deq   (deq),
      .kvi   (kvi),
      .kvo   (kvo),
      .full  (full),
      .empty (empty),
      .busy  (busy)
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
      ,
      .ovf   (ovf),
      .udf   (udf)
`endif
   );

`ifndef BUBBLE_PQ_ERR_FLAGS_EN
   assign ovf = 1'b0;
   assign udf = 1'b0;
`endif

   always #5 clk = ~clk;

   // Reference insert: new entry goes after every key <= its own; busy = entries it passes + 1.
   function automatic int m_insert(input logic [W-1:0] kv);
      int pos = q.size();
      for (int i = 0; i < q.size(); i++)
         if (q[i][W-1 -: KEY_W] > kv[W-1 -: KEY_W]) begin pos = i; break; end
      q.insert(pos, kv);
      return q.size() - pos;
   endfunction

   // Applies one accepted-in-idle request to the model; returns expected busy cycles.
   function automatic int m_apply(input logic e, input logic d, input logic [W-1:0] kv);
      if (e && d && q.size() > 0) begin
         void'(q.pop_front());
         return m_insert(kv);
      end
      if (e) begin
         if (q.size() < DEPTH) return m_insert(kv);
         m_ovf = 1'b1;
         return 0;
      end
      if (d) begin
         if (q.size() > 0) void'(q.pop_front());
         else m_udf = 1'b1;
      end
      return 0;
   endfunction

   task automatic run_op(input logic e, input logic d, input logic [W-1:0] kv, output int bc);
      @(negedge clk);
      enq = e; deq = d; kvi = kv;
      @(posedge clk); #1;
      enq = 1'b0; deq = 1'b0;
      bc = 0;
      while (busy === 1'b1 && bc < 64) begin
         bc++;
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      enq = 1'b0; deq = 1'b0; rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      q.delete();
      m_ovf = 1'b0; m_udf = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_tests++; if ({empty, full, busy} !== 3'b100) begin n_fail++;
         $display("FAIL reset_flags: got e/f/b=%b want 100", {empty, full, busy}); end
      n_tests++; if (kvo !== 16'h0000) begin n_fail++;
         $display("FAIL reset_kvo: got %h want 0000", kvo); end
      n_tests++; if ({ovf, udf} !== 2'b00) begin n_fail++;
         $display("FAIL reset_err: got ovf/udf=%b want 00", {ovf, udf}); end
   endtask

   task automatic test_ordered();
      logic [W-1:0] ins   [3] = '{16'h30A1, 16'h10B2, 16'h20C3};
      int           blen  [3] = '{1, 2, 2};
      logic [W-1:0] heads [3] = '{16'h10B2, 16'h20C3, 16'h30A1};
      int bc;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         void'(m_apply(1'b1, 1'b0, ins[i]));
         run_op(1'b1, 1'b0, ins[i], bc);
         n_tests++; if (bc !== blen[i]) begin n_fail++;
            $display("FAIL ordered_busy[%0d]: got %0d want %0d", i, bc, blen[i]); end
      end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if (kvo !== heads[i]) begin n_fail++;
            $display("FAIL ordered_head[%0d]: got %h want %h", i, kvo, heads[i]); end
         void'(m_apply(1'b0, 1'b1, '0));
         run_op(1'b0, 1'b1, '0, bc);
      end
      n_tests++; if (empty !== 1'b1) begin n_fail++;
         $display("FAIL ordered_empty: got %b want 1", empty); end
   endtask

   task automatic test_fill();
      int bc, exp;
      do_reset();
      for (int k = 8; k >= 1; k--) begin
         exp = m_apply(1'b1, 1'b0, {8'(k), 8'(k)});
         run_op(1'b1, 1'b0, {8'(k), 8'(k)}, bc);
         n_tests++; if (bc !== exp) begin n_fail++;
            $display("FAIL fill_busy[key %0d]: got %0d want %0d", k, bc, exp); end
      end
      n_tests++; if (bc !== 8) begin n_fail++;
         $display("FAIL fill_last_busy: got %0d want 8", bc); end
      n_tests++; if (full !== 1'b1) begin n_fail++;
         $display("FAIL fill_full: got %b want 1", full); end
      void'(m_apply(1'b1, 1'b0, 16'h0099));
      run_op(1'b1, 1'b0, 16'h0099, bc);
      n_tests++; if ({bc, kvo[W-1 -: KEY_W], full} !== {32'd0, 8'h01, 1'b1}) begin n_fail++;
         $display("FAIL fill_ninth: got busy=%0d key=%h full=%b want 0 01 1", bc, kvo[W-1 -: KEY_W], full); end
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
      n_tests++; if (ovf !== 1'b1) begin n_fail++;
         $display("FAIL fill_ovf: got %b want 1", ovf); end
`endif
   endtask

   task automatic test_replace();
      logic [W-1:0] drain [8] = '{16'h0212, 16'h0313, 16'h0414, 16'h0515,
                                  16'h05EE, 16'h0616, 16'h0717, 16'h0818};
      int bc;
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         void'(m_apply(1'b1, 1'b0, {8'(k), 8'(8'h10 + k)}));
         run_op(1'b1, 1'b0, {8'(k), 8'(8'h10 + k)}, bc);
      end
      void'(m_apply(1'b1, 1'b1, 16'h05EE));
      run_op(1'b1, 1'b1, 16'h05EE, bc);
      n_tests++; if ({full, bc} !== {1'b1, 32'd4}) begin n_fail++;
         $display("FAIL replace_full: got full=%b busy=%0d want 1 4", full, bc); end
      for (int i = 0; i < 8; i++) begin
         n_tests++; if (kvo !== drain[i]) begin n_fail++;
            $display("FAIL replace_drain[%0d]: got %h want %h", i, kvo, drain[i]); end
         void'(m_apply(1'b0, 1'b1, '0));
         run_op(1'b0, 1'b1, '0, bc);
      end
      n_tests++; if (empty !== 1'b1) begin n_fail++;
         $display("FAIL replace_empty: got %b want 1", empty); end
   endtask

   task automatic test_ties();
      int bc;
      do_reset();
      for (int i = 1; i <= 3; i++) begin
         void'(m_apply(1'b1, 1'b0, {8'h40, 8'(i)}));
         run_op(1'b1, 1'b0, {8'h40, 8'(i)}, bc);
         n_tests++; if (bc !== 1) begin n_fail++;
            $display("FAIL ties_busy[%0d]: got %0d want 1", i, bc); end
      end
      for (int i = 1; i <= 3; i++) begin
         n_tests++; if (kvo !== {8'h40, 8'(i)}) begin n_fail++;
            $display("FAIL ties_order[%0d]: got %h want %h", i, kvo, {8'h40, 8'(i)}); end
         void'(m_apply(1'b0, 1'b1, '0));
         run_op(1'b0, 1'b1, '0, bc);
      end
   endtask

   task automatic test_guards();
      int bc;
      do_reset();
      void'(m_apply(1'b0, 1'b1, '0));
      run_op(1'b0, 1'b1, '0, bc);
      n_tests++; if ({empty, busy, kvo} !== {1'b1, 1'b0, 16'h0000}) begin n_fail++;
         $display("FAIL guard_deq_empty: got e=%b b=%b kvo=%h want 1 0 0000", empty, busy, kvo); end
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
      n_tests++; if ({ovf, udf} !== 2'b01) begin n_fail++;
         $display("FAIL guard_udf: got ovf/udf=%b want 01", {ovf, udf}); end
`endif
      void'(m_apply(1'b1, 1'b1, 16'h5011));
      run_op(1'b1, 1'b1, 16'h5011, bc);
      n_tests++; if ({empty, full, bc, kvo} !== {1'b0, 1'b0, 32'd1, 16'h5011}) begin n_fail++;
         $display("FAIL guard_enqdeq_empty: got e=%b f=%b busy=%0d kvo=%h want 0 0 1 5011",
                  empty, full, bc, kvo); end
      // Insert that bubbles, with a second enq held high into its busy window.
      void'(m_apply(1'b1, 1'b0, 16'h1022));
      @(negedge clk); enq = 1'b1; kvi = 16'h1022;
      @(posedge clk); #1 kvi = 16'h0777;
      @(posedge clk); #1 enq = 1'b0;
      bc = 0;
      while (busy === 1'b1 && bc < 64) begin bc++; @(posedge clk); #1; end
      n_tests++; if (kvo !== 16'h1022) begin n_fail++;
         $display("FAIL guard_busy_head: got %h want 1022", kvo); end
      for (int i = 0; i < 2; i++) begin
         void'(m_apply(1'b0, 1'b1, '0));
         run_op(1'b0, 1'b1, '0, bc);
      end
      n_tests++; if (empty !== 1'b1) begin n_fail++;
         $display("FAIL guard_busy_ignored: got empty=%b want 1", empty); end
   endtask

   task automatic test_reset_mid_bubble();
      int bc;
      do_reset();
      for (int k = 8; k >= 2; k--) begin
         void'(m_apply(1'b1, 1'b0, {8'(k), 8'hAA}));
         run_op(1'b1, 1'b0, {8'(k), 8'hAA}, bc);
      end
      @(negedge clk); enq = 1'b1; kvi = 16'h01BB;
      @(posedge clk); #1 enq = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_tests++; if ({empty, full, busy, kvo} !== {3'b100, 16'h0000}) begin n_fail++;
         $display("FAIL midreset_async: got e/f/b=%b kvo=%h want 100 0000", {empty, full, busy}, kvo); end
      @(posedge clk);
      @(negedge clk) rst = 1'b1;
      q.delete(); m_ovf = 1'b0; m_udf = 1'b0;
      void'(m_apply(1'b1, 1'b0, 16'h3344));
      run_op(1'b1, 1'b0, 16'h3344, bc);
      void'(m_apply(1'b0, 1'b1, '0));
      run_op(1'b0, 1'b1, '0, bc);
      n_tests++; if ({empty, kvo} !== {1'b1, 16'h0000}) begin n_fail++;
         $display("FAIL midreset_no_residue: got e=%b kvo=%h want 1 0000", empty, kvo); end
   endtask

   task automatic test_random();
      int bc, exp;
      logic e, d;
      logic [W-1:0] kv;
      do_reset();
      for (int n = 0; n < 300; n++) begin
         e  = ($urandom_range(0, 99) < 55);
         d  = ($urandom_range(0, 99) < 45);
         kv = {8'($urandom_range(0, 15)), 8'($urandom)};
         exp = m_apply(e, d, kv);
         run_op(e, d, kv, bc);
         n_tests++; if (bc !== exp) begin n_fail++;
            $display("FAIL rand_busy[%0d]: got %0d want %0d", n, bc, exp); end
         n_tests++; if ({full, empty} !== {q.size() == DEPTH, q.size() == 0}) begin n_fail++;
            $display("FAIL rand_fe[%0d]: got f/e=%b%b want size %0d", n, full, empty, q.size()); end
         if (q.size() > 0) begin
            n_tests++; if (kvo !== q[0]) begin n_fail++;
               $display("FAIL rand_head[%0d]: got %h want %h", n, kvo, q[0]); end
         end
      end
`ifdef BUBBLE_PQ_ERR_FLAGS_EN
      n_tests++; if ({ovf, udf} !== {m_ovf, m_udf}) begin n_fail++;
         $display("FAIL rand_err: got ovf/udf=%b want %b", {ovf, udf}, {m_ovf, m_udf}); end
`endif
   endtask

   initial begin
      test_reset();
      test_ordered();
      test_fill();
      test_replace();
      test_ties();
      test_guards();
      test_reset_mid_bubble();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bubble_pq.md
Name: bubble_pq

Overview:
- Priority-queue device (responder) for the team's pq_if client/device protocol. Presents the flat equivalent of the dev modport signals, so it can be wrapped as a drop-in alternative to the existing heap, shift-register and pipelined-heap queues.
- Entries are kept in a sorted register array; lowest key = highest priority.
- Enqueue inserts at the tail and bubbles toward the head one compare-swap per cycle, holding busy meanwhile. Dequeue is single-cycle.

Parameters:
- DEPTH, 8, number of entries (power of 2 not required, >=2)
- KEY_W, 8, key width; entry upper field
- VAL_W, 8, value width; entry lower field

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset; rst=0 clears the block immediately
- enq  in  1  enqueue request, sampled on posedge when accepted
- deq  in  1  dequeue request, sampled on posedge when accepted
- kvi  in  KEY_W+VAL_W  entry to insert, {key,value}
- kvo  out  KEY_W+VAL_W  head entry (min key); valid when !empty && !busy
- full  out  1  count==DEPTH
- empty  out  1  count==0
- busy  out  1  insertion bubble in progress; requests ignored

Behaviour:
- Reset (rst low, async):
  - count=0, state=IDLE, all array entries=0.
  - Outputs: kvo=0, empty=1, full=0, busy=0.
  - Reset mid-bubble abandons the insertion with no partial entries retained.
- Storage: arr[0..DEPTH-1] is kept sorted, non-decreasing key from index 0. kvo=arr[0] (registered array, no combinational path from kvi). full/empty derive from registered count.
- FSM states: IDLE, BUBBLE. busy = (state==BUBBLE).
- IDLE, accept rules, evaluated on each posedge:
  - deq only: if !empty, shift arr[i]<=arr[i+1] for all i, arr[DEPTH-1]<=0, count--. New head is visible the next cycle (1-cycle latency). If empty, ignored.
  - enq only: if !full, arr[count]<=kvi, p<=count, count++, go to BUBBLE. If full, ignored (entry dropped).
  - enq && deq, !empty (replace): shift as for deq, write kvi at arr[count-1], p<=count-1, count unchanged, go to BUBBLE. This is legal when full.
  - enq && deq, empty: treated as enq only.
- BUBBLE, one compare per cycle:
  - if p!=0 and key(arr[p]) < key(arr[p-1]): swap the two entries, p--, stay in BUBBLE.
  - otherwise go to IDLE.
  - busy therefore stays high for (swaps+1) cycles. Worst case is DEPTH cycles.
- Requests while busy are ignored. The client must hold or reissue them; the protocol makes no queueing guarantee.
- Ties: the strict compare stops the bubble at an equal key, so equal keys dequeue in FIFO order.
- Key compare is unsigned on the upper KEY_W bits; the value field is carried untouched.
- count width is $clog2(DEPTH+1). It never wraps: enq-only is blocked at full and deq-only at empty.

Optional Feature:
- Macro: BUBBLE_PQ_ERR_FLAGS_EN.
- When defined, two extra outputs are present:
  - ovf (1 bit): sticky, set on an enq-only attempt while full in IDLE.
  - udf (1 bit): sticky, set on a deq-only attempt while empty in IDLE.
  - Both are cleared only by reset, reset value 0. Requests ignored because busy=1 do not set either flag.
- When undefined, the ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, release -> empty=1, full=0, busy=0, kvo=16'h0000. Assert rst=0 mid-bubble -> all outputs return to reset values in the same cycle, without waiting for a clock edge.
- Ordered insert: enq keys 0x30,0x10,0x20 (values 0xA1,0xB2,0xC3), waiting for !busy each time -> busy lengths 1,2,2 cycles. kvo=16'h10B2, then 16'h20C3, then 16'h30A1 after successive deqs; empty=1 after the third deq.
- Fill/full: enq 8 entries with keys 8..1 -> full=1 and the last insert is busy for 8 cycles. A 9th enq is ignored (with BUBBLE_PQ_ERR_FLAGS_EN: ovf=1). kvo key=0x01.
- Replace when full: full queue with keys 1..8; enq+deq together with key 0x05 -> count stays 8, full=1. Drain order: 2,3,4,5,5,6,7,8 with the old 5 before the new 5.
- Ties/FIFO: enq {0x40,0x01},{0x40,0x02},{0x40,0x03} -> each busy exactly 1 cycle. Deq order yields values 0x01,0x02,0x03.
- Busy/empty guards: enq during busy is ignored (count unchanged). deq on empty -> no change to count or kvo (with BUBBLE_PQ_ERR_FLAGS_EN: udf=1). enq+deq on empty -> behaves as enq only, count=1.
